// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU with NZCV flags.
//   alu_op_e   - 3-bit operation code (ALU_ADD .. ALU_CMP)
//   FLAG_*     - bit positions of N, Z, C, V inside the 4-bit flag register
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_ADC = 3'b010,
        ALU_SBC = 3'b011,
        ALU_AND = 3'b100,
        ALU_OR  = 3'b101,
        ALU_XOR = 3'b110,
        ALU_CMP = 3'b111
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_addsub_core.sv
// alu_addsub_core: combinational WIDTH-bit adder/subtractor.
//   a, b  in  operands
//   cin   in  carry-in (1 for plain subtract, stored C for carry-chained ops)
//   sub   in  1 = a + ~b + cin, 0 = a + b + cin
//   sum   out low WIDTH bits of the result
//   c     out carry-out (for subtract this is NOT borrow)
//   v     out signed overflow
module alu_addsub_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             c,
    output logic             v
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    always_comb begin
        b_eff = sub ? ~b : b;
        full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        sum   = full[WIDTH-1:0];
        c     = full[WIDTH];
        // overflow: operands of equal sign produced a result of the other sign
        v     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu_flags_pipe.sv
// alu_flags_pipe: two-stage pipelined ALU with an architectural NZCV register.
// Optional feature macro: ALU_SATURATE_EN (adds sat_mode, signed clamping of
// arithmetic results on overflow).
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  request handshake; op, a, b, set_flags latched on accept
//   sat_mode             (ALU_SATURATE_EN only) clamp on signed overflow
//   out_valid/out_ready  result handshake
//   result               registered result, held while stalled
//   flags                {N,Z,C,V}, committed when an op moves into stage 2
module alu_flags_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_flags,
`ifdef ALU_SATURATE_EN
    input  logic             sat_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic             s1_valid;
    alu_op_e          s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_sf;
`ifdef ALU_SATURATE_EN
    logic             s1_sat;
`endif

    logic             s1_advance;
    logic             accept;

    logic             core_cin;
    logic             core_sub;
    logic [WIDTH-1:0] core_sum;
    logic             core_c;
    logic             core_v;
    logic             is_arith;
    logic             sat_hit;
    logic [WIDTH-1:0] nxt_result;
    logic [3:0]       nxt_flags;

    always_comb begin
        s1_advance = s1_valid && (!out_valid || out_ready);
        in_ready   = rst_n && (!s1_valid || s1_advance);
        accept     = in_valid && in_ready;
    end

    // Carry-chained ops read flags directly: every older op has already
    // committed by the edge on which this op advances, so no stall is needed.
    always_comb begin
        core_sub = 1'b0;
        core_cin = 1'b0;
        case (s1_op)
            ALU_SUB, ALU_CMP: begin core_sub = 1'b1; core_cin = 1'b1; end
            ALU_ADC:          begin core_sub = 1'b0; core_cin = flags[FLAG_C]; end
            ALU_SBC:          begin core_sub = 1'b1; core_cin = flags[FLAG_C]; end
            default:          begin core_sub = 1'b0; core_cin = 1'b0; end
        endcase
    end

    alu_addsub_core #(.WIDTH(WIDTH)) u_core (
        .a   (s1_a),
        .b   (s1_b),
        .cin (core_cin),
        .sub (core_sub),
        .sum (core_sum),
        .c   (core_c),
        .v   (core_v)
    );

    always_comb begin
        is_arith = !s1_op[2] || (s1_op == ALU_CMP);
`ifdef ALU_SATURATE_EN
        sat_hit  = s1_sat && is_arith && core_v;
`else
        sat_hit  = 1'b0;
`endif
        case (s1_op)
            ALU_AND: nxt_result = s1_a & s1_b;
            ALU_OR:  nxt_result = s1_a | s1_b;
            ALU_XOR: nxt_result = s1_a ^ s1_b;
            default: nxt_result = core_sum;
        endcase
        // on overflow the sign of a tells which direction it went
        if (sat_hit) begin
            nxt_result = s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end

        nxt_flags = flags;
        if (s1_sf || (s1_op == ALU_CMP)) begin
            nxt_flags[FLAG_N] = nxt_result[WIDTH-1];
            nxt_flags[FLAG_Z] = (nxt_result == '0);
            if (is_arith) begin
                nxt_flags[FLAG_C] = core_c;
                nxt_flags[FLAG_V] = core_v;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_op    <= alu_op_e'(op);
                s1_a     <= a;
                s1_b     <= b;
                s1_sf    <= set_flags;
`ifdef ALU_SATURATE_EN
                s1_sat   <= sat_mode;
`endif
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end

            // flags commit only on advance, so a stalled output never re-commits
            if (s1_advance) begin
                out_valid <= 1'b1;
                result    <= nxt_result;
                flags     <= nxt_flags;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_flags_pipe.sv
// tb_alu_flags_pipe: directed and randomized checks of alu_flags_pipe (WIDTH=4)
// against an in-order arithmetic reference model with an expected-output queue.
module tb_alu_flags_pipe;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         set_flags = 1'b0;
    logic         sat_mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int checks = 0;
    int failures = 0;
    int ncyc = 0;

    typedef struct {
        int res;
        int flg;
        int e;
    } exp_t;
    exp_t q[$];

    int mf_n = 0, mf_z = 0, mf_c = 0, mf_v = 0;

`ifdef ALU_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    alu_flags_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .set_flags (set_flags),
`ifdef ALU_SATURATE_EN
        .sat_mode  (sat_mode),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ncyc++;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, ncyc);
        end
    endtask

    function automatic int mflags();
        return (mf_n << 3) | (mf_z << 2) | (mf_c << 1) | mf_v;
    endfunction

    // Reference: plain unsigned/signed integer arithmetic, ops applied in issue order.
    function automatic int model_op(input int o, input int ia, input int ib,
                                    input bit sf, input bit st);
        int sa, sb, u, sr, res, c, v, bi;
        bit arith;
        sa = (ia >= 8) ? ia - 16 : ia;
        sb = (ib >= 8) ? ib - 16 : ib;
        arith = (o < 4) || (o == 7);
        u = 0; sr = 0; c = 0;
        case (o)
            0: begin u = ia + ib; sr = sa + sb; c = (u > 15); end
            1, 7: begin u = ia - ib; sr = sa - sb; c = (ia >= ib); end
            2: begin u = ia + ib + mf_c; sr = sa + sb + mf_c; c = (u > 15); end
            3: begin bi = 1 - mf_c; u = ia - ib - bi; sr = sa - sb - bi; c = (ia >= ib + bi); end
            4: u = ia & ib;
            5: u = ia | ib;
            default: u = ia ^ ib;
        endcase
        res = u & 15;
        v = arith && (sr > 7 || sr < -8);
        if (SAT_EN && st && v) res = (sr > 7) ? 7 : 8;
        if (sf || o == 7) begin
            mf_n = (res >= 8);
            mf_z = (res == 0);
            if (arith) begin
                mf_c = c;
                mf_v = v;
            end
        end
        return res;
    endfunction

    task automatic step(input bit rn, input bit iv, input int o, input int ia, input int ib,
                        input bit sf, input bit ordy, input bit st);
        exp_t ent;
        @(negedge clk);
        rst_n = rn;
        in_valid = iv;
        op = o[2:0];
        a = ia[W-1:0];
        b = ib[W-1:0];
        set_flags = sf;
        out_ready = ordy;
        sat_mode = st;
        #1;
        check_val("in_ready", int'(in_ready), int'(rn && (q.size() < 2 || ordy)));
        check_val("out_valid", int'(out_valid), int'(q.size() > 0 && ncyc >= q[0].e + 1));
        if (out_valid && q.size() > 0) begin
            check_val("result", int'(result), q[0].res);
            check_val("flags", int'(flags), q[0].flg);
        end else if (q.size() == 0) begin
            check_val("flags_idle", int'(flags), mflags());
        end
        if (!rn) begin
            q.delete();
            mf_n = 0; mf_z = 0; mf_c = 0; mf_v = 0;
        end else begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (iv && in_ready) begin
                ent.res = model_op(o, ia, ib, sf, st);
                ent.flg = mflags();
                ent.e = ncyc + 1;
                q.push_back(ent);
            end
        end
    endtask

    task automatic idle(input bit ordy);
        step(1'b1, 1'b0, 0, 0, 0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        check_val("rst_result", int'(result), 0);
        check_val("rst_flags", int'(flags), 0);

        // SUB 2-3 -> 1111, N=1 C=0
        step(1'b1, 1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check_val("sub_res", int'(result), 4'b1111);
        check_val("sub_flags", int'(flags), 4'b1000);

        // ADD 7+1 then ADD 14+2
        step(1'b1, 1'b1, 0, 7, 1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 0, 14, 2, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        check_val("add_ovf_res", int'(result), 4'b1000);
        check_val("add_ovf_flags", int'(flags), 4'b1001);
        idle(1'b1);
        check_val("add_wrap_res", int'(result), 0);
        check_val("add_wrap_flags", int'(flags), 4'b0110);

        // back-to-back carry chain
        step(1'b1, 1'b1, 0, 15, 1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2, 0, 0, 1'b1, 1'b1, 1'b0);
        check_val("chain_no_stall", int'(in_ready), 1);
        idle(1'b1);
        idle(1'b1);
        check_val("chain_adc_res", int'(result), 1);

        // output stall with three ops offered
        step(1'b1, 1'b1, 0, 1, 1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1, 5, 2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 6, 3, 5, 1'b1, 1'b0, 1'b0);
        check_val("stall_in_ready", int'(in_ready), 0);
        step(1'b1, 1'b1, 6, 3, 5, 1'b1, 1'b0, 1'b0);
        check_val("stall_result", int'(result), 2);
        step(1'b1, 1'b1, 6, 3, 5, 1'b1, 1'b1, 1'b0);
        repeat (4) idle(1'b1);

        // reset with two ops in flight
        step(1'b1, 1'b1, 0, 3, 4, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 0, 5, 6, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        check_val("rst_mid_valid", int'(out_valid), 0);
        check_val("rst_mid_flags", int'(flags), 0);
        repeat (3) idle(1'b1);

`ifdef ALU_SATURATE_EN
        step(1'b1, 1'b1, 0, 7, 1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1, 8, 1, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        check_val("sat_add_res", int'(result), 4'b0111);
        check_val("sat_add_v", int'(flags[0]), 1);
        idle(1'b1);
        check_val("sat_sub_res", int'(result), 4'b1000);
        check_val("sat_sub_nv", int'({flags[3], flags[0]}), 3);
`endif

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(99) >= 3), ($urandom_range(99) < 75), int'($urandom_range(7)),
                 int'($urandom_range(15)), int'($urandom_range(15)), ($urandom_range(99) < 70),
                 ($urandom_range(99) < 65), ($urandom_range(1) == 1));
        end
        repeat (4) idle(1'b1);
        check_val("drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_flags_pipe.md
Name: alu_flags_pipe

Overview:
- Parametrised, pipelined successor to the team's n-bit subtractor.
- Supports add/sub/carry-chained/logic/compare ops on WIDTH-bit operands and holds an architectural NZCV flag register.
- Uses valid/ready handshakes on both sides and sits between the operand-fetch stage and writeback of the processor datapath.
- Carry-chained ops (ADC/SBC) read the stored C flag, enabling multi-word arithmetic.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request this cycle
op  in  3  operation code (see Behaviour)
a  in  WIDTH  operand A
b  in  WIDTH  operand B
set_flags  in  1  update NZCV when this op completes (CMP forces 1)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  WIDTH  computed result
flags  out  4  architectural {N,Z,C,V} register

Behaviour:
- Reset is synchronous on rst_n=0:
  - stage-1 valid, out_valid, result, flags all 0.
  - in_ready=0 while rst_n=0.
  - Reset mid-operation discards in-flight ops; no output is produced for them.
- Opcodes:
  - 000 ADD
  - 001 SUB (a-b)
  - 010 ADC (a+b+C)
  - 011 SBC (a-b-!C)
  - 100 AND
  - 101 OR
  - 110 XOR
  - 111 CMP (SUB; result driven, flags always updated)
- Arithmetic:
  - WIDTH+1-bit internal sum; result = low WIDTH bits (wrap).
  - C = carry-out for add.
  - For sub, C = NOT borrow (C=1 iff a >= b+borrow-in, unsigned).
  - V = signed overflow.
  - N = result[WIDTH-1]; Z = (result==0).
  - Logic ops update N,Z only; C,V are held.
- Pipeline: two register stages, latency 2 cycles from accept to out_valid.
  - Stage 1 latches op/a/b/set_flags on in_valid & in_ready.
  - Stage 2 computes on advance from stage 1 and registers result.
  - The flag register updates on that same edge (if set_flags or CMP).
- Flag hazard: an op reads the C flag at its own stage-1→2 advance edge.
  - All older ops have already committed their flags by then, so back-to-back ADC chains are correct with no stall.
- Handshake:
  - Stage 2 holds when out_valid & !out_ready.
  - Stage 1 advances when stage 2 is empty or draining.
  - in_ready = !s1_valid | s1_advance.
  - result/flags are stable while out_valid & !out_ready.
  - Full throughput is 1 op/cycle.
- Simultaneous accept and drain in the same cycle is allowed; no bubble is inserted.
- A flag update occurs only once per op, regardless of how long the output stalls.

Optional Feature:
- Macro ALU_SATURATE_EN.
- Defined:
  - Adds port sat_mode (in, 1), latched with the op.
  - When 1, ADD/SUB/ADC/SBC/CMP results clamp to the signed max 0111..1 or min 1000..0 on overflow.
  - V still reports the overflow; N and Z are computed from the clamped result.
- Undefined: port absent, results always wrap.

Decomposition:
- Package alu_pkg holds:
  - op enum (ALU_ADD..ALU_CMP, 3 bits)
  - flag bit-index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- One combinational sub-module, alu_addsub_core (WIDTH param; a, b, cin, sub → sum, c, v), instantiated once in stage 2.

Test Plan (WIDTH=4):
- SUB a=2,b=3,set_flags=1 → two cycles later result=1111, flags N=1,Z=0,C=0,V=0.
- ADD a=7,b=1 → result=1000, N=1,V=1,C=0; then ADD a=14,b=2 → result=0000, Z=1,C=1,V=0.
- Chain: ADD a=15,b=1 (C←1) back-to-back with ADC a=0,b=0 → second result=0001, with no stall between issues.
- Hold out_ready=0 for 3 cycles with 3 ops issued:
  - in_ready drops after 2 accepts.
  - result and flags stay constant while stalled.
  - Release gives results in order; flags are updated once per op.
- Assert rst_n=0 for one cycle with 2 ops in flight → next cycle out_valid=0, flags=0000, and no stale result ever appears.
- ALU_SATURATE_EN, sat_mode=1: ADD 7+1 → 0111 with V=1; SUB 8−1 (−8−1) → 1000 with V=1,N=1.
